car_pos_ctrl: RTL and testbench

//  Frame-synchronous position controller for the car sprite drawn by the sprite-draw stage.

---
 rtl/car_pos_ctrl_pkg.sv | 23 ++
 rtl/car_pos_ctrl_edge_rise.sv | 20 ++
 rtl/car_pos_ctrl.sv | 143 ++++++++++++++
 tb/tb_car_pos_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/car_pos_ctrl_pkg.sv
// Shared screen/sprite geometry and the FSM / steering encodings for the car
// position controller. The draw stage imports the same geometry.
package car_pos_ctrl_pkg;

    localparam int VGA_W = 800;
    localparam int VGA_H = 600;
    localparam int SPR_W = 128;
    localparam int SPR_H = 128;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_APPLY  = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_L     = 2'd1,
        DIR_R     = 2'd2
    } dir_e;

endpackage

// File: rtl/car_pos_ctrl_edge_rise.sv
// Registers a level and emits a one-cycle pulse on its rising edge.
module car_pos_ctrl_edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= RST_VAL;
        else     sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/car_pos_ctrl.sv
// Frame-synchronous car sprite position controller: samples steering at the
// start of vblank, ramps lateral speed and commits a clamped position once per frame.
module car_pos_ctrl
    import car_pos_ctrl_pkg::*;
#(
    parameter int SCREEN_W     = VGA_W,
    parameter int SCREEN_H     = VGA_H,
    parameter int RECT_WIDTH   = SPR_W,
    parameter int RECT_LENGTH  = SPR_H,
    parameter int X_INIT       = 336,
    parameter int Y_INIT       = 472,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int Y_STEP       = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        enable,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        visible,
    output logic [3:0]  speed,
    output logic        frame_tick
);

    localparam int AW = $clog2(ACCEL_FRAMES + 1);
    localparam logic [AW-1:0]      ACC_TOP = AW'(ACCEL_FRAMES);
    localparam logic [3:0]         SPD_MAX = 4'(MAX_SPEED);
    localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - RECT_WIDTH);
    localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - RECT_LENGTH);
    localparam logic signed [11:0] Y_STP   = 12'(Y_STEP);

    state_e             state_q;
    dir_e               dir_q, dir_d, hdir;
    logic [10:0]        xpos_q, ypos_q, x_d, y_d;
    logic [3:0]         speed_q, speed_d;
    logic [AW-1:0]      accel_q, accel_d, accel_inc;
    logic               visible_q, tick_q;
    logic               en_q, l_q, r_q, u_q, d_q;
    logic               vb_rise;
    logic signed [11:0] x_s, y_s, spd_s;

    // Edge flop resets high so a reset released mid-vblank waits for the next full rise.
    car_pos_ctrl_edge_rise #(.RST_VAL(1'b1)) u_vb_edge (
        .clk    (pclk),
        .rst    (rst),
        .sig_i  (vblnk_in),
        .rise_o (vb_rise)
    );

    always_comb begin
        dir_d     = DIR_NONE;
        speed_d   = 4'd0;
        accel_d   = '0;
        accel_inc = accel_q + 1'b1;
        hdir      = DIR_NONE;
        if (l_q & ~r_q)      hdir = DIR_L;
        else if (r_q & ~l_q) hdir = DIR_R;
        x_s = $signed({1'b0, xpos_q});
        y_s = $signed({1'b0, ypos_q});
        if (en_q) begin
            dir_d = hdir;
            if (hdir != DIR_NONE && hdir != dir_q) begin
                speed_d = 4'd1;
            end else if (hdir != DIR_NONE) begin
                speed_d = speed_q;
                accel_d = accel_inc;
                if (accel_inc == ACC_TOP) begin
                    accel_d = '0;
                    if (speed_q < SPD_MAX) speed_d = speed_q + 4'd1;
                end
            end
            spd_s = $signed({8'd0, speed_d});
            if (hdir == DIR_L)      x_s = x_s - spd_s;
            else if (hdir == DIR_R) x_s = x_s + spd_s;
            if (u_q & ~d_q)      y_s = y_s - Y_STP;
            else if (d_q & ~u_q) y_s = y_s + Y_STP;
            if (x_s < 12'sd0)      x_s = 12'sd0;
            else if (x_s > X_MAX)  x_s = X_MAX;
            if (y_s < 12'sd0)      y_s = 12'sd0;
            else if (y_s > Y_MAX)  y_s = Y_MAX;
        end else begin
            spd_s = 12'sd0;
        end
        x_d = x_s[10:0];
        y_d = y_s[10:0];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            xpos_q    <= 11'(X_INIT);
            ypos_q    <= 11'(Y_INIT);
            visible_q <= 1'b0;
            speed_q   <= 4'd0;
            tick_q    <= 1'b0;
            accel_q   <= '0;
            dir_q     <= DIR_NONE;
            en_q      <= 1'b0;
            l_q       <= 1'b0;
            r_q       <= 1'b0;
            u_q       <= 1'b0;
            d_q       <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                ST_WAIT: if (vb_rise) state_q <= ST_SAMPLE;
                ST_SAMPLE: begin
                    en_q    <= enable;
                    l_q     <= btn_left;
                    r_q     <= btn_right;
                    u_q     <= btn_up;
                    d_q     <= btn_down;
                    state_q <= ST_APPLY;
                end
                ST_APPLY: begin
                    xpos_q    <= x_d;
                    ypos_q    <= y_d;
                    speed_q   <= speed_d;
                    accel_q   <= accel_d;
                    dir_q     <= dir_d;
                    visible_q <= en_q;
                    tick_q    <= 1'b1;
                    state_q   <= ST_HOLD;
                end
                ST_HOLD: if (!vblnk_in) state_q <= ST_WAIT;
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign visible    = visible_q;
    assign speed      = speed_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_car_pos_ctrl.sv
// Directed frame vectors for car_pos_ctrl plus reset and vblank-glitch sequences.
module tb_car_pos_ctrl;

    logic        pclk, rst, vblnk_in, enable;
    logic        btn_left, btn_right, btn_up, btn_down;
    logic [10:0] xpos, ypos;
    logic        visible, frame_tick;
    logic [3:0]  speed;

    int tests = 0;
    int fails = 0;

    logic [10:0] px, py;
    logic [3:0]  ps;
    logic        pv;

    typedef struct {
        logic        en, l, r, u, d;
        int          rep;
        int          glitch;
        logic [10:0] ex, ey;
        logic [3:0]  es;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    car_pos_ctrl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .enable     (enable),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .xpos       (xpos),
        .ypos       (ypos),
        .visible    (visible),
        .speed      (speed),
        .frame_tick (frame_tick)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int en, l, r, u, d, rep, g, ex, ey, es, ev);
        vec_t v;
        v.en = 1'(en); v.l = 1'(l); v.r = 1'(r); v.u = 1'(u); v.d = 1'(d);
        v.rep = rep; v.glitch = g;
        v.ex = 11'(ex); v.ey = 11'(ey); v.es = 4'(es); v.ev = 1'(ev);
        tbl.push_back(v);
    endtask

    // One vblank: rise, commit two edges later, mid-frame button toggles, fall.
    task automatic frame(input vec_t v, input logic last_chk, input logic pre_chk, input string nm);
        int ticks;
        ticks = 0;
        @(negedge pclk);
        enable = v.en; btn_left = v.l; btn_right = v.r; btn_up = v.u; btn_down = v.d;
        vblnk_in = 1'b1;
        @(negedge pclk);
        if (frame_tick) ticks++;
        if (v.glitch == 1) vblnk_in = 1'b0;
        if (pre_chk) chk({nm, "_hold0"}, 32'({xpos, ypos, speed, visible}), 32'({px, py, ps, pv}));
        @(negedge pclk);
        if (frame_tick) ticks++;
        vblnk_in = (v.glitch == 2) ? 1'b0 : 1'b1;
        if (pre_chk) begin
            chk({nm, "_hold1"}, 32'({xpos, ypos, speed, visible}), 32'({px, py, ps, pv}));
            chk({nm, "_early_tick"}, 32'(ticks), 32'd0);
        end
        btn_left = ~v.l; btn_right = ~v.r; btn_up = ~v.u; btn_down = ~v.d; enable = ~v.en;
        @(negedge pclk);
        vblnk_in = 1'b1;
        if (last_chk) begin
            chk({nm, "_tick"}, 32'(frame_tick), 32'd1);
            chk({nm, "_x"}, 32'(xpos), 32'(v.ex));
            chk({nm, "_y"}, 32'(ypos), 32'(v.ey));
            chk({nm, "_spd"}, 32'(speed), 32'(v.es));
            chk({nm, "_vis"}, 32'(visible), 32'(v.ev));
        end
        if (frame_tick) ticks++;
        repeat (3) begin @(negedge pclk); if (frame_tick) ticks++; end
        vblnk_in = 1'b0;
        repeat (4) begin @(negedge pclk); if (frame_tick) ticks++; end
        chk({nm, "_ticks"}, 32'(ticks), 32'd1);
        chk({nm, "_range"}, 32'((xpos <= 11'd672) && (ypos <= 11'd472)), 32'd1);
    endtask

    task automatic run_tbl(input int from, input int to);
        for (int i = from; i < to; i++) begin
            for (int k = 0; k < tbl[i].rep; k++)
                frame(tbl[i], k == tbl[i].rep - 1, tbl[i].rep == 1, $sformatf("v%0d", i));
            px = tbl[i].ex; py = tbl[i].ey; ps = tbl[i].es; pv = tbl[i].ev;
        end
    endtask

    initial begin
        int ticks;
        rst = 1'b1; vblnk_in = 1'b0; enable = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;

        //      en l  r  u  d  rep g   x    y   spd vis
        add(0, 0, 0, 0, 0, 1,  0, 336, 472, 0, 0);
        add(1, 0, 1, 0, 0, 1,  0, 337, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0, 338, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0, 339, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0, 340, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0, 342, 472, 2, 1);
        add(1, 0, 1, 0, 0, 1,  0, 344, 472, 2, 1);
        add(1, 0, 1, 0, 0, 1,  0, 346, 472, 2, 1);
        add(1, 0, 1, 0, 0, 1,  0, 348, 472, 2, 1);
        add(1, 0, 1, 0, 0, 1,  0, 351, 472, 3, 1);
        add(1, 0, 1, 0, 0, 1,  0, 354, 472, 3, 1);
        add(1, 1, 0, 0, 0, 1,  0, 353, 472, 1, 1);
        add(1, 1, 1, 0, 0, 1,  0, 353, 472, 0, 1);
        add(1, 1, 0, 0, 0, 1,  0, 352, 472, 1, 1);
        add(0, 0, 1, 0, 0, 1,  0, 352, 472, 0, 0);
        add(1, 0, 0, 1, 0, 1,  0, 352, 470, 0, 1);
        add(1, 0, 0, 0, 1, 1,  0, 352, 472, 0, 1);
        add(1, 0, 0, 1, 1, 1,  0, 352, 472, 0, 1);
        add(1, 0, 0, 0, 1, 1,  0, 352, 472, 0, 1);
        add(1, 1, 0, 0, 1, 1,  0, 351, 472, 1, 1);
        add(1, 1, 0, 0, 0, 27, 0, 240, 472, 7, 1);
        add(1, 1, 0, 0, 0, 30, 0,   0, 472, 8, 1);
        add(1, 1, 0, 0, 0, 12, 0,   0, 472, 8, 1);
        add(1, 0, 1, 0, 0, 1,  0,   1, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0,   2, 472, 1, 1);
        add(1, 0, 1, 0, 0, 1,  0,   3, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0,   2, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0,   1, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0,   0, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0,   0, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0,   0, 472, 2, 1);
        add(1, 0, 1, 0, 0, 1,  0,   1, 472, 1, 1);
        add(1, 1, 1, 0, 0, 1,  0,   1, 472, 0, 1);
        add(1, 0, 1, 0, 0, 28, 0, 113, 472, 7, 1);
        add(1, 0, 1, 0, 0, 69, 0, 665, 472, 8, 1);
        add(1, 0, 1, 0, 0, 1,  0, 672, 472, 8, 1);
        add(1, 0, 1, 0, 0, 2,  0, 672, 472, 8, 1);
        add(1, 0, 0, 1, 0, 1,  1, 672, 470, 0, 1);
        add(1, 0, 0, 0, 1, 1,  2, 672, 472, 0, 1);
        add(1, 0, 1, 0, 0, 1,  1, 672, 472, 1, 1);
        add(1, 1, 0, 0, 0, 1,  0, 335, 472, 1, 1);

        #2;
        chk("rst_x", 32'(xpos), 32'd336);
        chk("rst_y", 32'(ypos), 32'd472);
        chk("rst_vis", 32'(visible), 32'd0);
        chk("rst_spd", 32'(speed), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        ticks = 0;
        repeat (6) begin @(negedge pclk); if (frame_tick) ticks++; end
        chk("post_rst_ticks", 32'(ticks), 32'd0);
        chk("post_rst_state", 32'({xpos, ypos, speed, visible}), 32'({11'd336, 11'd472, 4'd0, 1'b0}));
        px = 11'd336; py = 11'd472; ps = 4'd0; pv = 1'b0;

        run_tbl(0, tbl.size() - 1);

        // Reset lands while the FSM is in APPLY, vblank still high afterwards.
        @(negedge pclk);
        enable = 1'b1; btn_left = 1'b1; btn_right = 1'b0; vblnk_in = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'({xpos, ypos, speed, visible}), 32'({11'd336, 11'd472, 4'd0, 1'b0}));
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        @(negedge pclk);
        rst = 1'b0;
        ticks = 0;
        repeat (6) begin @(negedge pclk); if (frame_tick) ticks++; end
        vblnk_in = 1'b0;
        repeat (3) begin @(negedge pclk); if (frame_tick) ticks++; end
        chk("mid_rst_no_tick", 32'(ticks), 32'd0);
        chk("mid_rst_hold", 32'({xpos, ypos, speed, visible}), 32'({11'd336, 11'd472, 4'd0, 1'b0}));
        px = 11'd336; py = 11'd472; ps = 4'd0; pv = 1'b0;

        run_tbl(tbl.size() - 1, tbl.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
